// File: rtl/mpu_sequencer.sv
// Microprogram issuer for the MPU: stores control words and plays them onto c,
// one per clock, with multi-pass repeat, abort and illegal-op suppression.
module mpu_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [9:0]    prog_wdata,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    repeat_cnt,
  output logic [8:0]    c,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err_illegal
);

  localparam logic [8:0] NOP = 9'h000;

  // S_DONE is the cycle in which the final word sits on c; its edge raises done.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [8:0]    c_q, c_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    passes_q, passes_d;

  logic [9:0]    mem [DEPTH];

  logic [AW-1:0] issue_addr;
  logic [9:0]    word;
  logic          illegal;
  logic          is_last;
  logic          start_ok;
  logic          issuing;
  logic [7:0]    passes_now;

  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  always_comb begin
    issue_addr = (state_q == S_IDLE) ? '0 : pc_q;
    word       = mem[issue_addr];
    illegal    = (word[2:1] == 2'b11);
    is_last    = word[9] || (issue_addr == AW'(DEPTH - 1));
    start_ok   = (state_q == S_IDLE) && start && !abort;
    issuing    = start_ok || ((state_q == S_RUN) && !abort);
    passes_now = start_ok ? ((repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt) : passes_q;

    state_d  = state_q;
    c_d      = NOP;
    pc_d     = pc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    passes_d = passes_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start_ok) begin
          err_d = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pc_d    = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pc_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (issuing) begin
      c_d    = illegal ? NOP : word[8:0];
      err_d  = err_d | illegal;
      busy_d = 1'b1;
      if (is_last) begin
        pc_d = '0;
        if (passes_now > 8'd1) begin
          passes_d = passes_now - 8'd1;
          state_d  = S_RUN;
        end else begin
          passes_d = 8'd0;
          state_d  = S_DONE;
        end
      end else begin
        pc_d     = issue_addr + 1'b1;
        passes_d = passes_now;
        state_d  = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      c_q      <= NOP;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      passes_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      passes_q <= passes_d;
    end
  end

  assign c           = c_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Directed bench for mpu_sequencer: a 16-word instance driving a small MPU model,
// plus a 4-word instance for the address-wrap case.
module tb_mpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [9:0] prog_wdata;
  logic       start, start4;
  logic       abort;
  logic [7:0] repeat_cnt;

  logic [8:0] c, c4;
  logic [3:0] pc;
  logic [1:0] pc4;
  logic       busy, busy4, done, done4, err, err4;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_words [0:15];
  logic       exp_err;

  logic [7:0] r0, r1, r2, mpu_out;
  localparam logic [7:0] DATA_IN = 8'd5;

  always #5 clk = ~clk;

  mpu_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .abort(abort), .repeat_cnt(repeat_cnt),
    .c(c), .pc(pc), .busy(busy), .done(done), .err_illegal(err)
  );

  mpu_sequencer #(.DEPTH(4), .AW(2)) dut4 (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr[1:0]),
    .prog_wdata(prog_wdata), .start(start4), .abort(abort), .repeat_cnt(repeat_cnt),
    .c(c4), .pc(pc4), .busy(busy4), .done(done4), .err_illegal(err4)
  );

  function automatic logic [7:0] mpu_sel(input logic [1:0] s);
    case (s)
      2'b00:   mpu_sel = r0;
      2'b01:   mpu_sel = r1;
      2'b10:   mpu_sel = r2;
      default: mpu_sel = DATA_IN;
    endcase
  endfunction

  // Minimal MPU: executes the control word currently on c at each rising edge.
  always @(posedge clk) begin
    logic [7:0] a, b, res;
    if (rst) begin
      r0 <= 8'd0; r1 <= 8'd0; r2 <= 8'd0; mpu_out <= 8'd0;
    end else begin
      a = mpu_sel(c[4:3]);
      b = mpu_sel(c[6:5]);
      case (c[2:0])
        3'b001:  res = a + b;
        3'b010:  res = a - b;
        3'b011:  res = a & b;
        3'b100:  res = a | b;
        3'b101:  res = a ^ b;
        default: res = a;
      endcase
      case (c[8:7])
        2'b00:   r0 <= res;
        2'b01:   r1 <= res;
        2'b10:   r2 <= res;
        default: mpu_out <= res;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [9:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Start a run and check n words back-to-back, then the single done pulse.
  task automatic expect_run(input string tag, input int n, input logic [7:0] rep);
    repeat_cnt = rep;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_c%0d", tag, i), 32'(c), 32'(exp_words[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s_nodone%0d", tag, i), 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cnop"}, 32'(c), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    tick();
    chk({tag, "_donegone"}, 32'(done), 32'd0);
    $display("run %s: %0d words, repeat=%0d checked", tag, n, rep);
  endtask

  task automatic set3(input int base, input logic [8:0] w0, input logic [8:0] w1,
                      input logic [8:0] w2);
    exp_words[base] = w0; exp_words[base+1] = w1; exp_words[base+2] = w2;
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; start4 = 1'b0; abort = 1'b0; repeat_cnt = 8'd1;
    exp_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // 1: single pass, MPU computes out = 2*data_in
    load(4'd0, 10'h018); load(4'd1, 10'h081); load(4'd2, 10'h388);
    set3(0, 9'h018, 9'h081, 9'h188);
    expect_run("t1", 3, 8'd1);
    chk("t1_mpu_out", 32'(mpu_out), 32'h0A);

    // 2: two passes without a gap, then repeat 0 behaves as 1
    set3(3, 9'h018, 9'h081, 9'h188);
    expect_run("t2_rep2", 6, 8'd2);
    expect_run("t2_rep0", 3, 8'd0);

    // 3: illegal op suppressed, sticky until the next accepted start
    load(4'd1, 10'h006);
    set3(0, 9'h018, 9'h000, 9'h188);
    exp_err = 1'b1;
    expect_run("t3_ill", 3, 8'd1);
    tick();
    chk("t3_sticky", 32'(err), 32'd1);
    load(4'd1, 10'h081);
    set3(0, 9'h018, 9'h081, 9'h188);
    exp_err = 1'b0;
    repeat_cnt = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_clear", 32'(err), 32'd0);
    chk("t3_pc1", 32'(pc), 32'd1);
    tick(); tick(); tick(); tick();
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: start and prog_we mid-run are ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_w0", 32'(c), 32'h018);
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 10'h3FF;
    tick();
    start = 1'b0; prog_we = 1'b0;
    chk("t4_w1", 32'(c), 32'h081);
    tick();
    chk("t4_w2", 32'(c), 32'h188);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    tick();
    chk("t4_nostart", 32'(busy), 32'd0);
    expect_run("t4_reread", 3, 8'd1);

    // 5: abort beats start in IDLE, abort mid-run, reset mid-run
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_abort_idle", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t5_w1", 32'(c), 32'h081);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_c", 32'(c), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_pc", 32'(pc), 32'd0);
    tick();
    chk("t5_abort_nodone", 32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t5_retry_w1", 32'(c), 32'h081);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_c", 32'(c), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tick();
    chk("t5_rst_nodone", 32'(done), 32'd0);
    chk("t5_rst_stays", 32'(c), 32'd0);

    // 6: 4-deep memory, no last flags: wrap forces the final word
    load(4'd0, 10'h018); load(4'd1, 10'h081); load(4'd2, 10'h0A1); load(4'd3, 10'h188);
    exp_words[0] = 9'h018; exp_words[1] = 9'h081;
    exp_words[2] = 9'h0A1; exp_words[3] = 9'h188;
    repeat_cnt = 8'd1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_c%0d", i), 32'(c4), 32'(exp_words[i]));
      chk($sformatf("t6_busy%0d", i), 32'(busy4), 32'd1);
      tick();
    end
    chk("t6_done", 32'(done4), 32'd1);
    chk("t6_cnop", 32'(c4), 32'd0);
    tick();
    chk("t6_donegone", 32'(done4), 32'd0);
    chk("t6_idle", 32'(busy4), 32'd0);
    $display("run t6: 4 words on DEPTH=4 checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
